uart_tx_feeder: RTL

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// CPU-side FIFO feeding a UART transmitter: pops one word, pulses tx_start, holds datain_tx for FRAME_CLKS.
// Optional sticky overflow flag port `ovf` is built when macro UTXF_OVF_FLAG_EN is defined.
module uart_tx_feeder #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned FRAME_CLKS = 5760
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [6:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     tx_start,
  output logic [6:0]               datain_tx,
`ifdef UTXF_OVF_FLAG_EN
  output logic                     busy,
  output logic                     ovf
`else
  output logic                     busy
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 13;

  typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} state_t;

  state_t          state;
  logic [6:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   hold_cnt;
  logic [LW-1:0]   level_nxt_c;
  logic            push_c;
  logic            pop_c;

  // A write while full is dropped even when a pop happens in the same cycle.
  assign push_c = wr_en & ~full;
  assign pop_c  = (state == IDLE) & ~empty;

  always_comb begin
    level_nxt_c = level;
    if (push_c && !pop_c) begin
      level_nxt_c = level + LW'(1);
    end else if (!push_c && pop_c) begin
      level_nxt_c = level - LW'(1);
    end
  end

  // Storage carries no reset; the reset pointers make old contents unreachable.
  always_ff @(posedge clk) begin
    if (rst_n && push_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_nxt_c;
      empty <= (level_nxt_c == LW'(0));
      full  <= (level_nxt_c == LW'(DEPTH));
    end
  end

  // Launch sequencer: IDLE pops, LAUNCH pulses tx_start, HOLD keeps the word stable for the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_start  <= 1'b0;
      datain_tx <= '0;
      busy      <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop_c) begin
            datain_tx <= mem[rd_ptr];
            tx_start  <= 1'b1;
            busy      <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          hold_cnt <= CW'(FRAME_CLKS - 1);
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UTXF_OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (wr_en && full) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule
